ascon_fsm: RTL and testbench
============================

Name: ascon_fsm

Overview:
- Control FSM that sequences one ASCON-128 authenticated encryption over the shared round datapath: initial-state mux, xor_begin, one permutation round per cycle, xor_end, state, data, cipher and tag registers.
- Issues the round index and every XOR/register enable, and accepts 64-bit AD/plaintext blocks through a valid/ready handshake.
- Sits between the top-level wrapper (start/done, data stream) and the datapath.

Parameters:
NUM_AD_BLOCKS, 1, number of 64-bit associated-data blocks (>=1)
NUM_PT_BLOCKS, 4, number of 64-bit plaintext blocks (>=1)

Ports:
clock  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous reset, active low
i_start  input  1  start one encryption; sampled only in IDLE
i_data_valid  input  1  upstream AD/PT block valid
o_data_ready  output  1  FSM ready for next block
o_enable_data_reg  output  1  datapath captures the input block
o_round  output  4  round index to the constant-addition layer, 0..11
o_mux_select  output  1  0 = initial state (IV||K||N), 1 = state register
o_enable_xor_data_begin  output  1  xor_begin: state[0] ^= data
o_enable_xor_key_begin  output  1  xor_begin: state[1..2] ^= key
o_enable_xor_key_end  output  1  xor_end: state[3..4] ^= key
o_enable_xor_lsb_end  output  1  xor_end: state[4] LSB ^= 1 (domain separation)
o_enable_state_reg  output  1  state register loads round output
o_enable_cipher_reg  output  1  cipher register loads state[0] after xor_begin
o_enable_tag_reg  output  1  tag register loads state[3..4] after xor_end
o_done  output  1  encryption complete; held until next start

Behaviour:
- Reset (reset_n low at a rising edge): state is IDLE, round counter is 0, all outputs are 0. A reset mid-operation aborts in that cycle; no partial done.
- States are IDLE, INIT, AD_WAIT, AD, PT_WAIT, PT, FINAL, DONE.
- IDLE/DONE:
  - i_start=1 moves to INIT and loads the counter with 0.
  - o_done=1 only in DONE.
  - i_start is ignored in every other state.
- INIT (p12, counter 0..11, 12 cycles):
  - o_enable_state_reg=1 throughout.
  - o_mux_select=0 at counter 0, otherwise 1.
  - o_enable_xor_key_end=1 at counter 11.
  - Then moves to AD_WAIT.
- AD_WAIT / PT_WAIT:
  - o_data_ready=1.
  - A transfer occurs when i_data_valid is also 1 in the same cycle: o_enable_data_reg=1 combinationally, the counter loads 6, and the FSM moves to AD or PT (or FINAL on the last PT block).
  - Without valid the FSM waits indefinitely; all enables except ready stay 0.
- AD (p6, counter 6..11):
  - o_enable_xor_data_begin=1 at counter 6.
  - o_enable_xor_lsb_end=1 at counter 11 of the last AD block only.
  - Next state is AD_WAIT (more AD blocks) or PT_WAIT.
- PT (p6):
  - At counter 6: o_enable_xor_data_begin=1 and o_enable_cipher_reg=1.
  - Next state is PT_WAIT.
- Last PT block bypasses p6 and goes to FINAL with the counter loaded to 0.
- FINAL (p12, counter 0..11):
  - At counter 0: o_enable_xor_data_begin, o_enable_cipher_reg and o_enable_xor_key_begin are all 1.
  - At counter 11: o_enable_xor_key_end=1 and o_enable_tag_reg=1.
  - Then moves to DONE.
- o_enable_state_reg=1 in every INIT/AD/PT/FINAL cycle and 0 in wait/idle/done.
- o_mux_select=1 except INIT counter 0.
- Block counters:
  - AD count: ceil(log2(NUM_AD_BLOCKS+1)) bits; PT count: ceil(log2(NUM_PT_BLOCKS+1)) bits.
  - Both clear on start.
  - Each increments on its handshake; last block is when count == NUM-1.
- Round counter: 4-bit. It increments while in a round state and never exceeds 11. No wrap is reachable.
- Latency, NUM_AD=1 / NUM_PT=4, i_data_valid constantly 1, start sampled at cycle 0:
  - INIT occupies cycles 1-12.
  - Handshakes at cycles 13, 20, 27, 34, 41.
  - FINAL occupies cycles 42-53.
  - o_done rises at cycle 54.

Decomposition:
- ascon_pkg holds:
  - enum t_fsm_state;
  - ROUNDS_A=12, ROUND_START_B=6, LAST_ROUND=11;
  - the 4-bit round type.
- Sub-module ascon_round_counter:
  - ports: load, load value (0 or 6), increment enable;
  - output: o_round;
  - flags: o_last (==11) and o_first;
  - same clock/reset_n convention.

Test Plan:
1. Reset then start:
   - Hold reset_n=0 for 3 cycles with i_start=1 -> all outputs 0 and FSM stays in IDLE.
   - Release reset_n and pulse i_start -> o_mux_select=0 only at cycle 1; o_round counts 0..11 over cycles 1-12; o_enable_xor_key_end=1 at cycle 12 only.
2. Nominal run with i_data_valid=1:
   - Handshakes at cycles 13/20/27/34/41.
   - o_enable_xor_lsb_end=1 at cycle 19 only.
   - o_enable_cipher_reg=1 at cycles 21, 28, 35, 42.
   - o_enable_tag_reg=1 at cycle 53; o_done=1 from cycle 54.
3. Back-pressure: hold i_data_valid=0 for 5 cycles in PT_WAIT -> o_data_ready=1, o_enable_state_reg=0 and o_round frozen; run resumes one cycle after valid.
4. Start ignored while busy: pulse i_start at cycle 30 -> no change; o_done is still at cycle 54.
5. Reset mid-FINAL: reset_n=0 at cycle 45 -> next cycle is IDLE with all outputs 0; a new start yields nominal timing again.
6. Parameter sweep (NUM_AD_BLOCKS=2, NUM_PT_BLOCKS=1):
   - lsb_end fires only on the second AD block.
   - The single PT handshake goes directly to FINAL with xor_data_begin, xor_key_begin and cipher_reg all 1 in the same cycle.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON-128 control path.
package ascon_pkg;

  localparam int ROUNDS_A      = 12;
  localparam int ROUND_START_B = 6;
  localparam int LAST_ROUND    = 11;

  typedef logic [3:0] t_round;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_AD_WAIT = 3'd2,
    S_AD      = 3'd3,
    S_PT_WAIT = 3'd4,
    S_PT      = 3'd5,
    S_FINAL   = 3'd6,
    S_DONE    = 3'd7
  } t_fsm_state;

endpackage

// File: rtl/ascon_round_counter.sv
// Round index counter: loaded to 0 (p12) or 6 (p6), counts up, saturates at the last round.
module ascon_round_counter
  import ascon_pkg::*;
(
  input  logic   clock,
  input  logic   reset_n,
  input  logic   i_load,
  input  t_round i_load_value,
  input  logic   i_increment,
  output t_round o_round,
  output logic   o_first,
  output logic   o_last
);

  t_round round;
  logic   first;

  // Load has priority; increment never steps past the last round.
  // o_first marks the round directly after a load (the xor_begin slot of a phase).
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      round <= '0;
      first <= 1'b0;
    end else if (i_load) begin
      round <= i_load_value;
      first <= 1'b1;
    end else if (i_increment && (round != t_round'(LAST_ROUND))) begin
      round <= round + t_round'(1);
      first <= 1'b0;
    end
  end

  assign o_round = round;
  assign o_first = first;
  assign o_last  = (round == t_round'(LAST_ROUND));

endmodule

// File: rtl/ascon_fsm.sv
// Control FSM sequencing one ASCON-128 encryption over the shared round datapath.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for i_start after reset
// S_INIT    | p12 on IV||K||N, key xor at the end
// S_AD_WAIT | ready for the next associated-data block
// S_AD      | p6 on one AD block, domain-separation bit after the last
// S_PT_WAIT | ready for the next plaintext block
// S_PT      | p6 on one non-final PT block, cipher captured at round 6
// S_FINAL   | last PT block xor, key xor, p12, tag capture
// S_DONE    | result valid, o_done held until the next start
module ascon_fsm
  import ascon_pkg::*;
#(
  parameter int NUM_AD_BLOCKS = 1,
  parameter int NUM_PT_BLOCKS = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_start,
  input  logic       i_data_valid,
  output logic       o_data_ready,
  output logic       o_enable_data_reg,
  output logic [3:0] o_round,
  output logic       o_mux_select,
  output logic       o_enable_xor_data_begin,
  output logic       o_enable_xor_key_begin,
  output logic       o_enable_xor_key_end,
  output logic       o_enable_xor_lsb_end,
  output logic       o_enable_state_reg,
  output logic       o_enable_cipher_reg,
  output logic       o_enable_tag_reg,
  output logic       o_done
);

  localparam int AD_W = $clog2(NUM_AD_BLOCKS + 1);
  localparam int PT_W = $clog2(NUM_PT_BLOCKS + 1);

  t_fsm_state      state;
  logic [AD_W-1:0] ad_count;
  logic [PT_W-1:0] pt_count;
  logic            ad_last;

  logic   cnt_load;
  t_round cnt_load_value;
  logic   cnt_increment;
  t_round round;
  logic   round_first;
  logic   round_last;

  logic in_rounds;
  logic waiting;
  logic idle_like;
  logic handshake;
  logic pt_last_block;

  assign in_rounds     = (state == S_INIT) || (state == S_AD) ||
                         (state == S_PT)   || (state == S_FINAL);
  assign waiting       = (state == S_AD_WAIT) || (state == S_PT_WAIT);
  assign idle_like     = (state == S_IDLE) || (state == S_DONE);
  assign handshake     = waiting && i_data_valid;
  assign pt_last_block = (pt_count == PT_W'(NUM_PT_BLOCKS - 1));

  // Round counter control: start loads 0, a handshake loads 6 (or 0 for the final PT block).
  always_comb begin
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    if (idle_like && i_start) begin
      cnt_load = 1'b1;
    end else if (handshake) begin
      cnt_load = 1'b1;
      if (!((state == S_PT_WAIT) && pt_last_block)) begin
        cnt_load_value = t_round'(ROUND_START_B);
      end
    end
  end

  assign cnt_increment = in_rounds && !round_last;

  ascon_round_counter u_round_counter (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_load       (cnt_load),
    .i_load_value (cnt_load_value),
    .i_increment  (cnt_increment),
    .o_round      (round),
    .o_first      (round_first),
    .o_last       (round_last)
  );

  // State sequencing and AD/PT block bookkeeping.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      ad_count <= '0;
      pt_count <= '0;
      ad_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            state    <= S_INIT;
            ad_count <= '0;
            pt_count <= '0;
            ad_last  <= 1'b0;
          end
        end
        S_INIT: begin
          if (round_last) state <= S_AD_WAIT;
        end
        S_AD_WAIT: begin
          if (i_data_valid) begin
            ad_last  <= (ad_count == AD_W'(NUM_AD_BLOCKS - 1));
            ad_count <= ad_count + AD_W'(1);
            state    <= S_AD;
          end
        end
        S_AD: begin
          if (round_last) state <= ad_last ? S_PT_WAIT : S_AD_WAIT;
        end
        S_PT_WAIT: begin
          if (i_data_valid) begin
            pt_count <= pt_count + PT_W'(1);
            state    <= pt_last_block ? S_FINAL : S_PT;
          end
        end
        S_PT: begin
          if (round_last) state <= S_PT_WAIT;
        end
        S_FINAL: begin
          if (round_last) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath enables decoded from the registered state and round flags.
  always_comb begin
    o_data_ready            = waiting;
    o_enable_data_reg       = handshake;
    o_round                 = round;
    o_mux_select            = (state != S_IDLE) && !((state == S_INIT) && round_first);
    o_enable_xor_data_begin = round_first &&
                              ((state == S_AD) || (state == S_PT) || (state == S_FINAL));
    o_enable_xor_key_begin  = round_first && (state == S_FINAL);
    o_enable_cipher_reg     = round_first && ((state == S_PT) || (state == S_FINAL));
    o_enable_xor_key_end    = round_last && ((state == S_INIT) || (state == S_FINAL));
    o_enable_xor_lsb_end    = round_last && (state == S_AD) && ad_last;
    o_enable_tag_reg        = round_last && (state == S_FINAL);
    o_enable_state_reg      = in_rounds;
    o_done                  = (state == S_DONE);
  end

endmodule

// File: tb/tb_ascon_fsm.sv
// Directed bench for ascon_fsm: reset, nominal timing, back-pressure, busy start, abort, 2AD/1PT sweep.
module tb_ascon_fsm;

  typedef struct packed {
    logic       done;
    logic       tag;
    logic       cipher;
    logic       st;
    logic       lsb;
    logic       kend;
    logic       kbeg;
    logic       dbeg;
    logic       mux;
    logic [3:0] rnd;
    logic       dreg;
    logic       rdy;
  } ovec_t;

  logic clock = 1'b0;
  logic reset_n;
  logic start_a, valid_a, start_b, valid_b;

  logic       rdy_a, dreg_a, mux_a, dbeg_a, kbeg_a, kend_a, lsb_a, st_a, cipher_a, tag_a, done_a;
  logic [3:0] rnd_a;
  logic       rdy_b, dreg_b, mux_b, dbeg_b, kbeg_b, kend_b, lsb_b, st_b, cipher_b, tag_b, done_b;
  logic [3:0] rnd_b;

  ovec_t vec_a, vec_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  ascon_fsm #(.NUM_AD_BLOCKS(1), .NUM_PT_BLOCKS(4)) dut_a (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .i_start                 (start_a),
    .i_data_valid            (valid_a),
    .o_data_ready            (rdy_a),
    .o_enable_data_reg       (dreg_a),
    .o_round                 (rnd_a),
    .o_mux_select            (mux_a),
    .o_enable_xor_data_begin (dbeg_a),
    .o_enable_xor_key_begin  (kbeg_a),
    .o_enable_xor_key_end    (kend_a),
    .o_enable_xor_lsb_end    (lsb_a),
    .o_enable_state_reg      (st_a),
    .o_enable_cipher_reg     (cipher_a),
    .o_enable_tag_reg        (tag_a),
    .o_done                  (done_a)
  );

  ascon_fsm #(.NUM_AD_BLOCKS(2), .NUM_PT_BLOCKS(1)) dut_b (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .i_start                 (start_b),
    .i_data_valid            (valid_b),
    .o_data_ready            (rdy_b),
    .o_enable_data_reg       (dreg_b),
    .o_round                 (rnd_b),
    .o_mux_select            (mux_b),
    .o_enable_xor_data_begin (dbeg_b),
    .o_enable_xor_key_begin  (kbeg_b),
    .o_enable_xor_key_end    (kend_b),
    .o_enable_xor_lsb_end    (lsb_b),
    .o_enable_state_reg      (st_b),
    .o_enable_cipher_reg     (cipher_b),
    .o_enable_tag_reg        (tag_b),
    .o_done                  (done_b)
  );

  assign vec_a = {done_a, tag_a, cipher_a, st_a, lsb_a, kend_a, kbeg_a, dbeg_a, mux_a, rnd_a, dreg_a, rdy_a};
  assign vec_b = {done_b, tag_b, cipher_b, st_b, lsb_b, kend_b, kbeg_b, dbeg_b, mux_b, rnd_b, dreg_b, rdy_b};

  task automatic chk(input string tag, input ovec_t obs, input ovec_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected outputs, NUM_AD=1 / NUM_PT=4, valid always high, start sampled at cycle 0.
  function automatic ovec_t expect_nom(input int c);
    ovec_t e;
    logic  hs;
    int    s;
    e     = '0;
    hs    = (c == 13) || (c == 20) || (c == 27) || (c == 34) || (c == 41);
    e.mux = (c != 1);
    e.rdy = hs;
    e.dreg = hs;
    if (c >= 1 && c <= 12) begin
      e.st = 1'b1; e.rnd = 4'(c - 1); e.kend = (c == 12);
    end else if (c >= 14 && c <= 19) begin
      e.st = 1'b1; e.rnd = 4'(c - 8); e.dbeg = (c == 14); e.lsb = (c == 19);
    end else if ((c >= 21 && c <= 26) || (c >= 28 && c <= 33) || (c >= 35 && c <= 40)) begin
      s = (c <= 26) ? 21 : ((c <= 33) ? 28 : 35);
      e.st = 1'b1; e.rnd = 4'(c - s + 6); e.dbeg = (c == s); e.cipher = (c == s);
    end else if (c >= 42 && c <= 53) begin
      e.st = 1'b1; e.rnd = 4'(c - 42);
      e.dbeg = (c == 42); e.cipher = (c == 42); e.kbeg = (c == 42);
      e.kend = (c == 53); e.tag = (c == 53);
    end else begin
      e.rnd = 4'd11; e.done = (c >= 54);
    end
    return e;
  endfunction

  // Same run with valid low during cycles 20..24 (first PT_WAIT): everything after slips by 5.
  function automatic ovec_t expect_stall(input int c);
    ovec_t e;
    if (c < 20) return expect_nom(c);
    if (c <= 24) begin
      e = '0; e.rdy = 1'b1; e.mux = 1'b1; e.rnd = 4'd11;
      return e;
    end
    return expect_nom(c - 5);
  endfunction

  // Expected outputs, NUM_AD=2 / NUM_PT=1, valid always high.
  function automatic ovec_t expect_b(input int c);
    ovec_t e;
    logic  hs;
    int    s;
    e     = '0;
    hs    = (c == 13) || (c == 20) || (c == 27);
    e.mux = (c != 1);
    e.rdy = hs;
    e.dreg = hs;
    if (c >= 1 && c <= 12) begin
      e.st = 1'b1; e.rnd = 4'(c - 1); e.kend = (c == 12);
    end else if ((c >= 14 && c <= 19) || (c >= 21 && c <= 26)) begin
      s = (c <= 19) ? 14 : 21;
      e.st = 1'b1; e.rnd = 4'(c - s + 6); e.dbeg = (c == s); e.lsb = (c == 26);
    end else if (c >= 28 && c <= 39) begin
      e.st = 1'b1; e.rnd = 4'(c - 28);
      e.dbeg = (c == 28); e.cipher = (c == 28); e.kbeg = (c == 28);
      e.kend = (c == 39); e.tag = (c == 39);
    end else begin
      e.rnd = 4'd11; e.done = (c >= 40);
    end
    return e;
  endfunction

  task automatic run_nom(input int last, input int busy_start);
    for (int c = 1; c <= last; c++) begin
      tick();
      start_a = (c == busy_start);
      valid_a = 1'b1;
      #1;
      chk($sformatf("nom_c%0d", c), vec_a, expect_nom(c));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    start_a = 1'b1;
    start_b = 1'b1;
    valid_a = 1'b0;
    valid_b = 1'b0;

    // Reset held with start asserted: everything stays at zero.
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk($sformatf("rst_a_%0d", i), vec_a, '0);
      chk($sformatf("rst_b_%0d", i), vec_b, '0);
    end

    // Nominal run, with a start pulse at cycle 30 that must be ignored.
    reset_n = 1'b1;
    start_b = 1'b0;
    start_a = 1'b1;
    valid_a = 1'b1;
    run_nom(56, 30);

    // Restart from DONE, abort with reset in FINAL at cycle 45.
    start_a = 1'b1;
    for (int c = 1; c <= 47; c++) begin
      tick();
      start_a = 1'b0;
      reset_n = (c != 45);
      #1;
      if (c <= 45) chk($sformatf("abort_c%0d", c), vec_a, expect_nom(c));
      else         chk($sformatf("abort_idle_c%0d", c), vec_a, '0);
    end

    // Fresh start after the abort gives nominal timing again.
    start_a = 1'b1;
    run_nom(55, 0);

    // Back-pressure in the first PT_WAIT.
    start_a = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      start_a = 1'b0;
      valid_a = !(c >= 20 && c <= 24);
      #1;
      chk($sformatf("stall_c%0d", c), vec_a, expect_stall(c));
    end

    // Two AD blocks, one PT block.
    start_b = 1'b1;
    valid_b = 1'b1;
    for (int c = 1; c <= 41; c++) begin
      tick();
      start_b = 1'b0;
      #1;
      chk($sformatf("sweep_c%0d", c), vec_b, expect_b(c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
